// File: rtl/ipdc_param.sv
// Parametrised image display controller: holds an IMG_W x IMG_H multi-channel image and
// streams a WIN x WIN window (shifted, mirrored or channel-averaged) on a valid-only bus.
module ipdc_param #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int WIN   = 4,
  parameter int CH    = 3,
  parameter int BW    = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_op_valid,
  input  logic [2:0]       i_op_mode,
  input  logic             i_in_valid,
  input  logic [CH*BW-1:0] i_in_data,
  output logic             o_op_ready,
  output logic             o_in_ready,
  output logic             o_out_valid,
  output logic [CH*BW-1:0] o_out_data
);
  localparam int XL   = $clog2(IMG_W);
  localparam int YL   = $clog2(IMG_H);
  localparam int WL   = $clog2(WIN);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int WSQ  = WIN * WIN;
  localparam int CL   = 2 * WL + 1;  // window counter; the value WSQ marks "stream finished"
  localparam int AW   = BW + 2 * WL;

  typedef enum logic [1:0] {IDLE, LOAD, DISP, MEAN} state_t;

  state_t           state;
  logic [CH*BW-1:0] mem [NPIX];
  logic [XL-1:0]    ox, nx_ox, rd_ox;
  logic [YL-1:0]    oy, nx_oy, rd_oy;
  logic             mirror, rd_mirror, loaded;
  logic [CL-1:0]    cnt, rd_idx;
  logic [XL+YL-1:0] wr_addr, rd_addr;
  logic [WL-1:0]    rd_row, rd_col;
  logic [AW-1:0]    acc [CH];
  logic [AW-1:0]    sum [CH];
  logic [CH*BW-1:0] rd_pix, mean_pix;

  // Saturating origin update requested by the op currently on the bus.
  always_comb begin
    // NOTE: defaults first so every path assigns each signal and no latch is inferred.
    nx_ox = ox;
    nx_oy = oy;
    case (i_op_mode)
      3'd1: if (int'(ox) + WIN < IMG_W) nx_ox = ox + 1'b1;
      3'd2: if (ox != '0) nx_ox = ox - 1'b1;
      3'd3: if (int'(oy) + WIN < IMG_H) nx_oy = oy + 1'b1;
      3'd4: if (oy != '0) nx_oy = oy - 1'b1;
      3'd7: begin
        nx_ox = '0;
        nx_oy = '0;
      end
      default: ;
    endcase
  end

  // The first window pixel is fetched on the accept edge, so it must see the new origin.
  always_comb begin
    rd_ox     = ox;
    rd_oy     = oy;
    rd_mirror = mirror;
    rd_idx    = cnt;
    if (state == IDLE) begin
      rd_ox     = nx_ox;
      rd_oy     = nx_oy;
      rd_mirror = (i_op_mode == 3'd5);
      rd_idx    = '0;
    end else if (state == LOAD) begin
      rd_ox     = '0;
      rd_oy     = '0;
      rd_mirror = 1'b0;
      rd_idx    = '0;
    end
  end

  assign rd_row  = rd_idx[2*WL-1:WL];
  assign rd_col  = rd_mirror ? ~rd_idx[WL-1:0] : rd_idx[WL-1:0];
  assign rd_addr = {rd_oy + YL'(rd_row), rd_ox + XL'(rd_col)};
  assign rd_pix  = mem[rd_addr];

  always_comb begin
    for (int c = 0; c < CH; c++) begin
      sum[c] = acc[c] + AW'(rd_pix[c*BW +: BW]);
      mean_pix[c*BW +: BW] = BW'(sum[c] >> (2 * WL));
    end
  end

  // NOTE: image storage is deliberately kept out of reset; only control state is cleared.
  always_ff @(posedge i_clk) begin
    if (!i_rst && state == LOAD && i_in_valid && o_in_ready) mem[wr_addr] <= i_in_data;
  end

  // NOTE: all state uses non-blocking assignments so every register updates together at the edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state       <= IDLE;
      ox          <= '0;
      oy          <= '0;
      mirror      <= 1'b0;
      loaded      <= 1'b0;
      cnt         <= '0;
      wr_addr     <= '0;
      for (int c = 0; c < CH; c++) acc[c] <= '0;
      o_op_ready  <= 1'b0;
      o_in_ready  <= 1'b0;
      o_out_valid <= 1'b0;
      o_out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_op_valid && o_op_ready) begin
            o_op_ready <= 1'b0;
            if (i_op_mode == 3'd0) begin
              state      <= LOAD;
              o_in_ready <= 1'b1;
              wr_addr    <= '0;
            end else begin
              ox     <= nx_ox;
              oy     <= nx_oy;
              mirror <= (i_op_mode == 3'd5);
              for (int c = 0; c < CH; c++) acc[c] <= '0;
              if (!loaded) begin
                state <= DISP;
                cnt   <= CL'(WSQ);
              end else if (i_op_mode == 3'd6) begin
                state <= MEAN;
                cnt   <= '0;
              end else begin
                state       <= DISP;
                cnt         <= CL'(1);
                o_out_valid <= 1'b1;
                o_out_data  <= rd_pix;
              end
            end
          end else begin
            o_op_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (i_in_valid && o_in_ready) begin
            wr_addr <= wr_addr + 1'b1;
            if (wr_addr == (XL+YL)'(NPIX - 1)) begin
              o_in_ready  <= 1'b0;
              ox          <= '0;
              oy          <= '0;
              mirror      <= 1'b0;
              loaded      <= 1'b1;
              state       <= DISP;
              cnt         <= CL'(1);
              o_out_valid <= 1'b1;
              o_out_data  <= rd_pix;
            end
          end
        end
        DISP: begin
          if (cnt == CL'(WSQ)) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_op_ready  <= 1'b1;
            state       <= IDLE;
          end else begin
            o_out_valid <= 1'b1;
            o_out_data  <= rd_pix;
            cnt         <= cnt + 1'b1;
          end
        end
        MEAN: begin
          if (cnt == CL'(WSQ)) begin
            o_out_valid <= 1'b0;
            o_out_data  <= '0;
            o_op_ready  <= 1'b1;
            state       <= IDLE;
          end else begin
            for (int c = 0; c < CH; c++) acc[c] <= sum[c];
            cnt <= cnt + 1'b1;
            if (cnt == CL'(WSQ - 1)) begin
              o_out_valid <= 1'b1;
              o_out_data  <= mean_pix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ipdc_param.sv
// Self-checking bench for ipdc_param: scenario tasks compared against a window-level model
// of the image, origin and loaded flag.
module tb_ipdc_param;
  localparam int IMG_W = 8, IMG_H = 8, WIN = 4, CH = 3, BW = 8;
  localparam int NPIX = IMG_W * IMG_H;
  localparam int WSQ  = WIN * WIN;
  localparam int DW   = CH * BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic [2:0]    op_mode = 3'd0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          op_ready, in_ready, out_valid;
  logic [DW-1:0] out_data;

  int total = 0;
  int bad   = 0;

  ipdc_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .CH(CH), .BW(BW)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_op_valid (op_valid),
    .i_op_mode  (op_mode),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_op_ready (op_ready),
    .o_in_ready (in_ready),
    .o_out_valid(out_valid),
    .o_out_data (out_data)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0] ref_mem [NPIX];
  int            ref_ox = 0, ref_oy = 0;
  bit            ref_loaded = 1'b0;

  // Observed and expected results of the most recent op
  logic [DW-1:0] got_data [$];
  int            got_cyc [$];
  int            ready_cyc;
  logic [DW-1:0] exp_data [$];
  int            exp_cyc [$];
  int            exp_ready;

  function automatic logic [DW-1:0] pat(input int n);
    pat = {8'(n + 128), 8'(n + 64), 8'(n)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies an op to the model and builds the expected output stream (cycles relative to accept).
  function automatic void model_op(input int mode);
    logic [DW-1:0] m;
    int s, col;
    exp_data.delete();
    exp_cyc.delete();
    case (mode)
      1: if (ref_ox + WIN < IMG_W) ref_ox++;
      2: if (ref_ox > 0) ref_ox--;
      3: if (ref_oy + WIN < IMG_H) ref_oy++;
      4: if (ref_oy > 0) ref_oy--;
      7: begin
        ref_ox = 0;
        ref_oy = 0;
      end
      default: ;
    endcase
    if (!ref_loaded) begin
      exp_ready = 2;
      return;
    end
    if (mode == 6) begin
      m = '0;
      for (int ch = 0; ch < CH; ch++) begin
        s = 0;
        for (int r = 0; r < WIN; r++)
          for (int c = 0; c < WIN; c++)
            s += int'(ref_mem[(ref_oy + r) * IMG_W + ref_ox + c][ch*BW +: BW]);
        m[ch*BW +: BW] = BW'(s / WSQ);
      end
      exp_data.push_back(m);
      exp_cyc.push_back(WSQ + 1);
      exp_ready = WSQ + 2;
    end else begin
      for (int r = 0; r < WIN; r++)
        for (int c = 0; c < WIN; c++) begin
          col = (mode == 5) ? WIN - 1 - c : c;
          exp_data.push_back(ref_mem[(ref_oy + r) * IMG_W + ref_ox + col]);
          exp_cyc.push_back(r * WIN + c + 1);
        end
      exp_ready = WSQ + 1;
    end
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (op_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    total++;
    if (op_ready !== 1'b1) begin
      bad++;
      $display("FAIL wait_ready: op_ready=%b required 1", op_ready);
    end
  endtask

  // Called in cycle k+1 (k = accept edge); records outputs until op_ready returns.
  task automatic collect(input string name, input int budget);
    int nz;
    nz = 0;
    got_data.delete();
    got_cyc.delete();
    ready_cyc = -1;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (out_valid === 1'b1) begin
        got_data.push_back(out_data);
        got_cyc.push_back(cyc);
      end else if (out_data !== '0) begin
        nz++;
      end
      if (op_ready === 1'b1) begin
        ready_cyc = cyc;
        break;
      end
      tick();
    end
    total++;
    if (nz != 0) begin
      bad++;
      $display("FAIL %s idle_data: %0d cycles with nonzero data, required 0", name, nz);
    end
  endtask

  task automatic verify(input string name);
    total++;
    if (ready_cyc != exp_ready) begin
      bad++;
      $display("FAIL %s ready_cycle: got %0d required %0d", name, ready_cyc, exp_ready);
    end
    total++;
    if (got_data.size() != exp_data.size()) begin
      bad++;
      $display("FAIL %s out_count: got %0d required %0d", name, got_data.size(), exp_data.size());
    end else begin
      for (int i = 0; i < exp_data.size(); i++) begin
        total++;
        if (got_data[i] !== exp_data[i] || got_cyc[i] != exp_cyc[i]) begin
          bad++;
          $display("FAIL %s out[%0d]: got %h at cycle %0d required %h at cycle %0d",
                   name, i, got_data[i], got_cyc[i], exp_data[i], exp_cyc[i]);
        end
      end
    end
  endtask

  task automatic run_op(input int mode, input string name);
    wait_ready();
    op_valid = 1'b1;
    op_mode  = 3'(mode);
    tick();
    op_valid = 1'b0;
    model_op(mode);
    collect(name, WSQ + 8);
    verify(name);
  endtask

  task automatic load_image(input bit pattern, input string name);
    int  n, guard, drop;
    bit  take;
    n = 0;
    guard = 0;
    drop = 0;
    wait_ready();
    for (int i = 0; i < NPIX; i++) ref_mem[i] = pattern ? pat(i) : DW'($urandom);
    op_valid = 1'b1;
    op_mode  = 3'd0;
    tick();
    op_valid = 1'b0;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s in_ready_start: got %b required 1", name, in_ready);
    end
    while (n < NPIX && guard < 1000) begin
      in_valid = ($urandom_range(3) != 0);
      in_data  = in_valid ? ref_mem[n] : DW'($urandom);
      if (in_ready !== 1'b1) drop++;
      take = in_valid && (in_ready === 1'b1);
      tick();
      if (take) n++;
      guard++;
    end
    in_valid = 1'b0;
    total++;
    if (n != NPIX || drop != 0) begin
      bad++;
      $display("FAIL %s accepts: got %0d (in_ready low %0d cycles) required %0d", name, n, drop, NPIX);
    end
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL %s in_ready_end: got %b required 0", name, in_ready);
    end
    ref_loaded = 1'b1;
    ref_ox = 0;
    ref_oy = 0;
    model_op(0);
    collect(name, WSQ + 8);
    verify(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if ({op_ready, in_ready, out_valid, out_data} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %b %b %b %h required all 0", op_ready, in_ready, out_valid, out_data);
    end
    rst = 1'b0;
    tick();
    total++;
    if (op_ready !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got op_ready=%b in_ready=%b out_valid=%b required 1 0 0",
               op_ready, in_ready, out_valid);
    end
    ref_loaded = 1'b0;
    ref_ox = 0;
    ref_oy = 0;
    run_op(3, "unloaded_down");
  endtask

  task automatic test_load();
    load_image(1'b1, "load_pattern");
    total++;
    if (got_data.size() != WSQ || got_data[0] !== 24'h804000 || got_data[WSQ-1] !== 24'h9b5b1b) begin
      bad++;
      $display("FAIL load_ends: got %0d outputs, first %h last %h required 804000 9b5b1b",
               got_data.size(), got_data.size() > 0 ? got_data[0] : '0,
               got_data.size() > 0 ? got_data[got_data.size()-1] : '0);
    end
  endtask

  task automatic test_shift_right();
    run_op(7, "home");
    for (int i = 1; i <= 5; i++) begin
      run_op(1, $sformatf("right%0d", i));
      if (i >= 4) begin
        total++;
        if (got_data.size() != WSQ || got_data[0] !== pat(4) || got_data[WSQ-1] !== pat(31)) begin
          bad++;
          $display("FAIL right%0d_window: got %0d outputs first %h, required first %h last %h",
                   i, got_data.size(), got_data.size() > 0 ? got_data[0] : '0, pat(4), pat(31));
        end
      end
    end
  endtask

  task automatic test_up_down();
    run_op(7, "home");
    run_op(4, "up_at_top");
    total++;
    if (got_data.size() == 0 || got_data[0] !== pat(0)) begin
      bad++;
      $display("FAIL up_at_top_first: got %h required %h", got_data.size() > 0 ? got_data[0] : '0, pat(0));
    end
    for (int i = 1; i <= 4; i++) run_op(3, $sformatf("down%0d", i));
    total++;
    if (got_data.size() == 0 || got_data[0] !== pat(32)) begin
      bad++;
      $display("FAIL down_final_first: got %h required %h", got_data.size() > 0 ? got_data[0] : '0, pat(32));
    end
  endtask

  task automatic test_mirror();
    run_op(7, "home");
    run_op(5, "mirror");
    total++;
    if (got_data.size() < WIN || got_data[0] !== pat(3) || got_data[1] !== pat(2) ||
        got_data[2] !== pat(1) || got_data[3] !== pat(0)) begin
      bad++;
      $display("FAIL mirror_row0: got %0d outputs first %h required %h %h %h %h",
               got_data.size(), got_data.size() > 0 ? got_data[0] : '0, pat(3), pat(2), pat(1), pat(0));
    end
  endtask

  task automatic test_mean();
    run_op(7, "home");
    run_op(6, "mean");
    total++;
    if (got_data.size() != 1 || got_data[0] !== 24'h8d4d0d || got_cyc[0] != 17) begin
      bad++;
      $display("FAIL mean_value: got %0d outputs first %h at %0d required 8d4d0d at 17",
               got_data.size(), got_data.size() > 0 ? got_data[0] : '0,
               got_cyc.size() > 0 ? got_cyc[0] : -1);
    end
  endtask

  task automatic test_idle_input();
    int hi;
    hi = 0;
    wait_ready();
    in_valid = 1'b1;
    in_data  = '1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (in_ready !== 1'b0) hi++;
    end
    in_valid = 1'b0;
    total++;
    if (hi != 0) begin
      bad++;
      $display("FAIL idle_in_ready: high %0d cycles required 0", hi);
    end
    run_op(7, "after_idle_input");
  endtask

  task automatic test_random();
    int mode;
    load_image(1'b0, "load_random");
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(7, 1);
      run_op(mode, $sformatf("rand%0d_mode%0d", i, mode));
    end
  endtask

  task automatic test_reset_mid();
    wait_ready();
    op_valid = 1'b1;
    op_mode  = 3'd7;
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    total++;
    if (out_valid !== 1'b1) begin
      bad++;
      $display("FAIL mid_8th_valid: got %b required 1", out_valid);
    end
    rst = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0 || op_ready !== 1'b0 || out_data !== '0) begin
      bad++;
      $display("FAIL mid_reset: got valid=%b ready=%b data=%h required 0 0 0", out_valid, op_ready, out_data);
    end
    rst = 1'b0;
    tick();
    total++;
    if (op_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_release: got ready=%b valid=%b required 1 0", op_ready, out_valid);
    end
    ref_loaded = 1'b0;
    ref_ox = 0;
    ref_oy = 0;
    run_op(1, "unloaded_right");
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift_right();
    test_up_down();
    test_mirror();
    test_mean();
    test_idle_input();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ipdc_param.md
Name: ipdc_param

Overview:
- Parametrised image display controller; successor to the fixed 8x8 RGB display block.
- Stores a full IMG_W x IMG_H multi-channel image in internal registers and keeps a WIN x WIN display window.
- Performs window shifts, mirror display and window channel-mean operations, and streams the results on a valid-only output bus.
- Sits between the host pixel/op interface and the downstream display sink.

Parameters:
- IMG_W, 8, image width in pixels; power of 2, at least WIN.
- IMG_H, 8, image height in pixels; power of 2, at least WIN.
- WIN, 4, display window edge; power of 2, at least 2.
- CH, 3, channels per pixel.
- BW, 8, bits per channel.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_op_valid  in  1  op request; sampled only when o_op_ready=1.
- i_op_mode  in  3  op code, valid with i_op_valid.
- i_in_valid  in  1  pixel valid during load.
- i_in_data  in  CH*BW  pixel; channel 0 in the LSBs.
- o_op_ready  out  1  block idle, can accept an op.
- o_in_ready  out  1  block accepting load pixels.
- o_out_valid  out  1  o_out_data valid this cycle.
- o_out_data  out  CH*BW  output pixel.

Behaviour:
- Reset (i_rst=1 at an edge, any state): all outputs go to 0, state goes to IDLE, origin (ox,oy)=(0,0), loaded flag=0. Image storage is not cleared. Reset mid-operation aborts the operation immediately. o_op_ready=1 from the first edge with i_rst=0.
- States: IDLE, LOAD, DISP, MEAN.
- All outputs are registered.
- Op acceptance: an op is accepted at an edge where i_op_valid && o_op_ready. o_op_ready drops to 0 in the next cycle. i_op_valid is ignored when o_op_ready=0.
- i_in_valid is ignored outside LOAD.
- Mode 0, load:
  - IDLE->LOAD. o_in_ready=1 from cycle k+1, where k is the accept edge.
  - A pixel is written on each edge with i_in_valid && o_in_ready, in raster order (address y*IMG_W+x). Gaps in i_in_valid are allowed.
  - After pixel IMG_W*IMG_H-1 is accepted, o_in_ready=0 in the next cycle. Then origin=(0,0), loaded=1, and the FSM goes to DISP.
- Modes 1-4 shift the origin, then DISP. Each shift saturates, leaving the origin unchanged at the edge:
  - Mode 1, right: ox+1 if ox+WIN<IMG_W.
  - Mode 2, left: ox-1 if ox>0.
  - Mode 3, down: oy+1 if oy+WIN<IMG_H.
  - Mode 4, up: oy-1 if oy>0.
- Mode 5, mirror display: DISP with each window row emitted right-to-left. Origin and storage are unchanged.
- Mode 6, mean: MEAN.
  - Accumulates the WIN*WIN window pixels over WIN*WIN cycles into per-channel accumulators of BW+2*log2(WIN) bits.
  - Emits one pixel; each channel = sum >> (2*log2(WIN)), truncating with no rounding.
  - o_out_valid is high for exactly 1 cycle, on cycle k+WIN*WIN+1.
- Mode 7, home: origin=(0,0), then DISP.
- DISP:
  - o_out_valid=1 for WIN*WIN consecutive cycles k+1..k+WIN*WIN.
  - Output order is window raster: row oy..oy+WIN-1, column ox..ox+WIN-1, or reversed column order for mode 5.
  - For load, DISP starts the cycle after the last pixel is accepted.
- Op completion: o_op_ready=1 in the cycle after the last o_out_valid. o_out_valid=0 and o_out_data=0 whenever no output is valid.
- Not loaded: when loaded=0, modes 1-7 are accepted and the origin still updates, but nothing is emitted. o_op_ready returns to 1 two cycles after the accept edge.
- No simultaneous-event hazards exist because ops are accepted only in IDLE.

Test Plan:
- Reset then load 64 pixels, with pixel n = {n, n+64, n+128} (defaults) -> o_in_ready high for exactly 64 accepts. Then 16 outputs of rows 0-3, columns 0-3: first 0x804000, last 0x9b5b1b (n=27). o_op_ready=1 after.
- Shift right 5 times after load -> the 4th and 5th shifts both display window ox=4. First pixel n=4 for both; last pixel n=31.
- Shift up at oy=0, then shift down 4 times -> the up-shift yields an unchanged window. The final window starts at n=32.
- Mode 5 at origin (0,0) -> the first row is output as n=3,2,1,0.
- Mode 6 at origin (0,0) -> a single pixel with channel 0 = (sum of n in window)/16 = 216/16 = 13 (0x0d). Channel 1 = 77 (0x4d), channel 2 = 141 (0x8d). o_out_valid is high for 1 cycle, on cycle k+17.
- Mid-operation and handshake checks:
  - Assert i_rst during the 8th DISP output -> o_out_valid=0 next cycle. o_op_ready=1 after release. A following mode 1 with loaded=0 produces no output.
  - Assert i_in_valid while in IDLE -> the pixel is ignored.
